// File: rtl/crc_pkg.sv
// Shared types and default constants for the serial CRC generator.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SHIFT_IN  = 2'd1,
        SHIFT_OUT = 2'd2
    } crc_state_t;

    localparam int unsigned CRC_DEF_WIDTH = 8;
    localparam logic [31:0] CRC_DEF_TAPS  = 32'h0000_00B4;
    localparam logic [31:0] CRC_DEF_SEED  = 32'h0000_00D8;

endpackage

// File: rtl/crc_serial_gen_lfsr.sv
// Right-shift Galois LFSR register: step with feedback, plain zero-fill shift, seed load.
module crc_lfsr
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH = CRC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(CRC_DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRC_DEF_SEED)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_step,
    input  logic             i_data,
    input  logic             i_shift,
    input  logic             i_load,
    output logic [WIDTH-1:0] o_lfsr
);

    logic [WIDTH-1:0] r_lfsr;
    logic             w_fb;

    assign w_fb   = i_data ^ r_lfsr[0];
    assign o_lfsr = r_lfsr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            r_lfsr <= SEED;
        end else if (i_step) begin
            r_lfsr <= (r_lfsr >> 1) ^ ({WIDTH{w_fb}} & TAPS);
        end else if (i_shift) begin
            r_lfsr <= r_lfsr >> 1;
        end
    end

endmodule

// File: rtl/crc_serial_gen.sv
// Bit-serial CRC generator: absorbs a frame while active, then emits WIDTH CRC bits LSB first.
// Optional residue check output crc_ok is enabled by defining CRC_CHECK_EN.
module crc_serial_gen
    import crc_pkg::*;
#(
    parameter int unsigned      WIDTH = CRC_DEF_WIDTH,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(CRC_DEF_TAPS),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(CRC_DEF_SEED)
) (
    input  logic clk,
    input  logic reset,
    input  logic data,
    input  logic active,
    output logic CRC,
    output logic valid,
    output logic busy
`ifdef CRC_CHECK_EN
    ,
    output logic crc_ok
`endif
);

    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    crc_state_t       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_lfsr;
    logic             w_more;
    logic             w_step;
    logic             w_shift;
    logic             w_load;

    // Input is only absorbed outside SHIFT_OUT; active seen while emitting is dropped.
    assign w_more  = (r_cnt < LAST);
    assign w_step  = active && (r_state == IDLE || r_state == SHIFT_IN);
    assign w_shift = (r_state == SHIFT_IN && !active) || (r_state == SHIFT_OUT && w_more);
    assign w_load  = (r_state == SHIFT_OUT) && !w_more;

    crc_lfsr #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (reset),
        .i_step  (w_step),
        .i_data  (data),
        .i_shift (w_shift),
        .i_load  (w_load),
        .o_lfsr  (w_lfsr)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            CRC     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (active) r_state <= SHIFT_IN;
                end
                SHIFT_IN: begin
                    if (!active) begin
                        r_state <= SHIFT_OUT;
                        CRC     <= w_lfsr[0];
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        r_cnt   <= CW'(1);
                    end
                end
                SHIFT_OUT: begin
                    if (w_more) begin
                        CRC   <= w_lfsr[0];
                        r_cnt <= r_cnt + CW'(1);
                    end else begin
                        CRC     <= 1'b0;
                        valid   <= 1'b0;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef CRC_CHECK_EN
    // Residue is judged on the register before the first output shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_ok <= 1'b0;
        end else if (r_state == IDLE && active) begin
            crc_ok <= 1'b0;
        end else if (r_state == SHIFT_IN && !active) begin
            crc_ok <= (w_lfsr == '0);
        end
    end
`endif

endmodule
